pixel_sram_responder: RTL and testbench
=======================================

Name: pixel_sram_responder

Overview:
- Avalon-MM pipelined-read responder serving the VGA subsystem's pixel DMA master: it is the memory end of the pixel_dma_master port.
- Sits between the system interconnect and the DE2-115 16-bit asynchronous SRAM that holds the pixel frame buffer.
- Accepts one read per clock with fixed latency and returns 16-bit pixels.
- Also accepts single-word byte-enabled writes so the CPU can fill the frame buffer through the same port.

Parameters:
- ADDR_W, 20, SRAM word-address width (1M x 16).
- READ_LATENCY, 2, cycles from SRAM address drive to data capture; must be ≥1.
- MAX_PENDING, 4, maximum accepted-but-unreturned reads; must be ≥ READ_LATENCY+1 for full throughput.

Ports:
- sys_clk_clk  in  1  system clock.
- sys_reset_reset_n  in  1  asynchronous active-low reset.
- pixel_slave_address  in  32  byte address; word = address[ADDR_W:1], higher bits ignored (wrap).
- pixel_slave_read  in  1  read request.
- pixel_slave_write  in  1  write request.
- pixel_slave_writedata  in  16  write data.
- pixel_slave_byteenable  in  2  write byte lanes.
- pixel_slave_lock  in  1  accepted and ignored (single-port responder).
- pixel_slave_readdata  out  16  returned pixel.
- pixel_slave_readdatavalid  out  1  readdata qualifier.
- pixel_slave_waitrequest  out  1  request not accepted this cycle.
- sram_ADDR  out  ADDR_W  SRAM word address.
- sram_DQ_in  in  16  SRAM data from pad.
- sram_DQ_out  out  16  SRAM data to pad.
- sram_DQ_oe  out  1  pad output enable.
- sram_CE_N, sram_OE_N, sram_WE_N, sram_UB_N, sram_LB_N  out  1 each  active-low SRAM controls.

Behaviour:
Single clock sys_clk_clk; reset sys_reset_reset_n is asynchronous and active-low.

Reset values:
- readdata = 0, readdatavalid = 0, waitrequest = 1.
- sram_ADDR = 0, all *_N = 1, DQ_oe = 0, DQ_out = 0.
- Pending count = 0; state = IDLE.
- In-flight reads are discarded; no readdatavalid is issued for them after reset releases.

Acceptance:
- A request is accepted on an edge where read or write is high and waitrequest is low.

FSM:
- IDLE:
  - waitrequest = read && pending==MAX_PENDING, or write && (pending!=0 || read).
  - read and write in the same cycle is a master error; the read is served and the write is held off by waitrequest.
- WRITE (1 cycle):
  - CE_N=0, WE_N=0 only if byteenable≠0, OE_N=1, DQ_oe=1.
  - UB_N=!be[1], LB_N=!be[0]; address and data are registered at the accept edge.
  - waitrequest=1; next state TURN.
- TURN (1 cycle):
  - WE_N=1, DQ_oe=0, waitrequest=1; next state IDLE (bus turnaround).

Reads:
- At the accept edge: sram_ADDR ← word, CE_N=OE_N=UB_N=LB_N=0, DQ_oe=0.
- A valid bit enters a READ_LATENCY-deep shift pipe.
- sram_DQ_in is registered into readdata as the bit exits.
- readdatavalid is high exactly READ_LATENCY+1 cycles after the accept cycle, for one cycle per read, in issue order.
- Back-to-back reads give one result per clock.
- Idle cycles: CE_N=OE_N=1.

Pending counter:
- +1 on accepted read, −1 on readdatavalid, unchanged when both happen.
- Never exceeds MAX_PENDING.

Writes:
- Accepted only when pending==0, so the DQ bus never conflicts with returning reads.
- Write-to-next-accept spacing is 3 cycles.
- A write with byteenable=0 runs the same FSM with no WE pulse.

Test Plan:
- Reset mid-burst: 3 reads in flight, assert reset → outputs at reset values, zero readdatavalid afterwards, pending=0.
- 8 back-to-back reads at addresses 0x0..0xE with SRAM model returning word index → readdatavalid continuous for 8 cycles, first at accept+3, data 0..7 in order, waitrequest never high.
- MAX_PENDING=2, READ_LATENCY=2, continuous reads → waitrequest asserts on the third request and throughput is 2 reads per 3 cycles; no lost or duplicated data.
- Write 0xA5C3 to 0x100 with byteenable=2'b01 → one WE_N low cycle, LB_N=0, UB_N=1, DQ_oe=1; then TURN; read back returns 0xxxC3 with the upper byte unchanged.
- Write issued while 2 reads are pending → waitrequest high until pending=0, then write accepted; both read results returned intact.
- Simultaneous read+write in IDLE → read accepted, write stalled one cycle; address 0x0020_0002 wraps to word 1.

Source files
------------

// File: rtl/pixel_sram_responder.sv
// Avalon-MM pipelined-read responder in front of the 16-bit asynchronous pixel SRAM.
// Reads are fixed-latency and can stream one per clock. Byte-enabled writes run a three-cycle WRITE/TURN sequence.
module pixel_sram_responder #(
  parameter int ADDR_W       = 20,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4
) (
  input  logic              sys_clk_clk,
  input  logic              sys_reset_reset_n,
  input  logic [31:0]       pixel_slave_address,
  input  logic              pixel_slave_read,
  input  logic              pixel_slave_write,
  input  logic [15:0]       pixel_slave_writedata,
  input  logic [1:0]        pixel_slave_byteenable,
  input  logic              pixel_slave_lock,
  output logic [15:0]       pixel_slave_readdata,
  output logic              pixel_slave_readdatavalid,
  output logic              pixel_slave_waitrequest,
  output logic [ADDR_W-1:0] sram_ADDR,
  input  logic [15:0]       sram_DQ_in,
  output logic [15:0]       sram_DQ_out,
  output logic              sram_DQ_oe,
  output logic              sram_CE_N,
  output logic              sram_OE_N,
  output logic              sram_WE_N,
  output logic              sram_UB_N,
  output logic              sram_LB_N
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {IDLE, WRITE, TURN} state_t;

  state_t                  state, state_next;
  logic [PEND_W-1:0]       pending;
  logic [READ_LATENCY-1:0] valid_pipe;
  logic [ADDR_W-1:0]       word;
  logic                    rd_accept, wr_accept, pipe_exit;
  logic                    pend_full, pend_any;
  logic                    unused_inputs;

  assign word          = pixel_slave_address[ADDR_W:1];
  assign pipe_exit     = valid_pipe[READ_LATENCY-1];
  assign pend_full     = (pending == PEND_W'(MAX_PENDING));
  assign pend_any      = (pending != '0);
  assign unused_inputs = &{1'b0, pixel_slave_lock, pixel_slave_address[31:ADDR_W+1],
                           pixel_slave_address[0]};

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) state <= IDLE;
    else                    state <= state_next;
  end

  // A read raised together with a write is still served; waitrequest then only stalls the write.
  always_comb begin
    state_next              = state;
    rd_accept               = 1'b0;
    wr_accept               = 1'b0;
    pixel_slave_waitrequest = 1'b1;
    case (state)
      IDLE: begin
        pixel_slave_waitrequest = (pixel_slave_read && pend_full) ||
                                  (pixel_slave_write && (pend_any || pixel_slave_read));
        rd_accept = pixel_slave_read && !pend_full;
        wr_accept = pixel_slave_write && !pixel_slave_read && !pend_any;
        if (wr_accept) state_next = WRITE;
      end
      WRITE:   state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!sys_reset_reset_n) pixel_slave_waitrequest = 1'b1;
  end

  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      sram_ADDR   <= '0;
      sram_DQ_out <= '0;
      sram_DQ_oe  <= 1'b0;
      sram_CE_N   <= 1'b1;
      sram_OE_N   <= 1'b1;
      sram_WE_N   <= 1'b1;
      sram_UB_N   <= 1'b1;
      sram_LB_N   <= 1'b1;
    end else if (rd_accept) begin
      sram_ADDR  <= word;
      sram_DQ_oe <= 1'b0;
      sram_CE_N  <= 1'b0;
      sram_OE_N  <= 1'b0;
      sram_WE_N  <= 1'b1;
      sram_UB_N  <= 1'b0;
      sram_LB_N  <= 1'b0;
    end else if (wr_accept) begin
      sram_ADDR   <= word;
      sram_DQ_out <= pixel_slave_writedata;
      sram_DQ_oe  <= 1'b1;
      sram_CE_N   <= 1'b0;
      sram_OE_N   <= 1'b1;
      sram_WE_N   <= (pixel_slave_byteenable == 2'b00);
      sram_UB_N   <= !pixel_slave_byteenable[1];
      sram_LB_N   <= !pixel_slave_byteenable[0];
    end else begin
      sram_DQ_oe <= 1'b0;
      sram_CE_N  <= 1'b1;
      sram_OE_N  <= 1'b1;
      sram_WE_N  <= 1'b1;
      sram_UB_N  <= 1'b1;
      sram_LB_N  <= 1'b1;
    end
  end

  // The pending count drops on the capture edge, so a write never drives DQ while a read is returning.
  always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
    if (!sys_reset_reset_n) begin
      valid_pipe                <= '0;
      pending                   <= '0;
      pixel_slave_readdata      <= '0;
      pixel_slave_readdatavalid <= 1'b0;
    end else begin
      valid_pipe[0] <= rd_accept;
      for (int i = 1; i < READ_LATENCY; i++) valid_pipe[i] <= valid_pipe[i-1];
      pixel_slave_readdatavalid <= pipe_exit;
      if (pipe_exit) pixel_slave_readdata <= sram_DQ_in;
      case ({rd_accept, pipe_exit})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sram_responder.sv
// Self-checking bench for pixel_sram_responder. Instance 0 has MAX_PENDING=4 and instance 1 has MAX_PENDING=2.
// A transaction-level model tracks accepts and expected returns, and it is compared against both instances every cycle.
module tb_pixel_sram_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  rd, wr, lock;
  logic [31:0] addr [2];
  logic [15:0] wdata [2];
  logic [1:0]  be [2];
  logic [15:0] dq_in [2];

  wire  [15:0] rdata [2];
  wire  [15:0] dq_out [2];
  wire  [19:0] sadr [2];
  wire  [1:0]  rdv, wreq, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

  always #5 clk = ~clk;

  pixel_sram_responder #(.ADDR_W(20), .READ_LATENCY(LAT), .MAX_PENDING(4)) dut (
    .sys_clk_clk(clk), .sys_reset_reset_n(rst_n),
    .pixel_slave_address(addr[0]), .pixel_slave_read(rd[0]), .pixel_slave_write(wr[0]),
    .pixel_slave_writedata(wdata[0]), .pixel_slave_byteenable(be[0]), .pixel_slave_lock(lock[0]),
    .pixel_slave_readdata(rdata[0]), .pixel_slave_readdatavalid(rdv[0]),
    .pixel_slave_waitrequest(wreq[0]), .sram_ADDR(sadr[0]), .sram_DQ_in(dq_in[0]),
    .sram_DQ_out(dq_out[0]), .sram_DQ_oe(dq_oe[0]), .sram_CE_N(ce_n[0]), .sram_OE_N(oe_n[0]),
    .sram_WE_N(we_n[0]), .sram_UB_N(ub_n[0]), .sram_LB_N(lb_n[0]));

  pixel_sram_responder #(.ADDR_W(20), .READ_LATENCY(LAT), .MAX_PENDING(2)) dut2 (
    .sys_clk_clk(clk), .sys_reset_reset_n(rst_n),
    .pixel_slave_address(addr[1]), .pixel_slave_read(rd[1]), .pixel_slave_write(wr[1]),
    .pixel_slave_writedata(wdata[1]), .pixel_slave_byteenable(be[1]), .pixel_slave_lock(lock[1]),
    .pixel_slave_readdata(rdata[1]), .pixel_slave_readdatavalid(rdv[1]),
    .pixel_slave_waitrequest(wreq[1]), .sram_ADDR(sadr[1]), .sram_DQ_in(dq_in[1]),
    .sram_DQ_out(dq_out[1]), .sram_DQ_oe(dq_oe[1]), .sram_CE_N(ce_n[1]), .sram_OE_N(oe_n[1]),
    .sram_WE_N(we_n[1]), .sram_UB_N(ub_n[1]), .sram_LB_N(lb_n[1]));

  typedef struct {
    int          inst;
    int          cap;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] got0[$], got1[$];
  logic [15:0] mem_model [4096];
  logic [15:0] mem_pin [4096];
  int          cyc = 0;
  int          n_checks = 0, n_fail = 0;
  int          max_pend [2];
  int          last_rd [2], last_wr [2];
  logic [19:0] rd_word [2], wr_word [2];
  logic [15:0] wr_data [2];
  logic [1:0]  wr_be [2];
  int          t0;

  // The pin-level SRAM has one register of read delay, so data captured at the Nth edge matches the address driven at edge N-2.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ce_n[0] && !we_n[0]) begin
      if (!lb_n[0]) mem_pin[sadr[0][11:0]][7:0]  <= dq_out[0][7:0];
      if (!ub_n[0]) mem_pin[sadr[0][11:0]][15:8] <= dq_out[0][15:8];
    end
    dq_in[0] <= mem_pin[sadr[0][11:0]];
    dq_in[1] <= sadr[1][15:0];
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int          idx, pend;
    logic        exp_rdv, busy, exp_wait, rdacc, wracc;
    logic [19:0] w;
    if (!rst_n) begin
      chk("rst_readdata", k, rdata[k], 0);
      chk("rst_rdv", k, rdv[k], 0);
      chk("rst_waitreq", k, wreq[k], 1);
      chk("rst_addr", k, sadr[k], 0);
      chk("rst_ctrl_n", k, {ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k]}, 5'b11111);
      chk("rst_dq", k, {dq_oe[k], dq_out[k]}, 0);
      for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].inst == k) exp_q.delete(i);
      last_rd[k] = -100;
      last_wr[k] = -100;
      return;
    end
    idx  = -1;
    pend = 0;
    foreach (exp_q[i]) if (exp_q[i].inst == k) begin
      if (idx < 0) idx = i;
      pend++;
    end
    exp_rdv = (idx >= 0) && (exp_q[idx].cap == cyc);
    chk("readdatavalid", k, rdv[k], exp_rdv);
    if (exp_rdv) begin
      chk("readdata", k, rdata[k], exp_q[idx].data);
      exp_q.delete(idx);
      pend--;
    end
    if (rdv[k] === 1'b1) begin
      if (k == 0) got0.push_back(rdata[k]);
      else        got1.push_back(rdata[k]);
    end
    if (cyc == last_rd[k]) begin
      chk("rd_addr", k, sadr[k], rd_word[k]);
      chk("rd_ctrl", k, {ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k], dq_oe[k]}, 6'b001000);
    end else if (cyc == last_wr[k]) begin
      chk("wr_addr", k, sadr[k], wr_word[k]);
      chk("wr_data", k, dq_out[k], wr_data[k]);
      chk("wr_ctrl", k, {ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k], dq_oe[k]},
          {1'b0, 1'b1, wr_be[k] == 2'b00, !wr_be[k][1], !wr_be[k][0], 1'b1});
    end else if (cyc == last_wr[k] + 1) begin
      chk("turn_ctrl", k, {we_n[k], dq_oe[k]}, 2'b10);
    end else begin
      chk("idle_ctrl", k, {ce_n[k], oe_n[k], we_n[k], dq_oe[k]}, 4'b1110);
    end
    busy     = (cyc == last_wr[k]) || (cyc == last_wr[k] + 1);
    exp_wait = busy || (rd[k] && pend == max_pend[k]) || (wr[k] && (pend != 0 || rd[k]));
    chk("waitrequest", k, wreq[k], exp_wait);
    rdacc = !busy && rd[k] && (pend < max_pend[k]);
    wracc = !busy && wr[k] && !rd[k] && (pend == 0);
    w     = 20'(addr[k] >> 1);
    if (rdacc) begin
      exp_q.push_back('{k, cyc + 1 + LAT, (k == 0) ? mem_model[w[11:0]] : w[15:0]});
      last_rd[k] = cyc + 1;
      rd_word[k] = w;
    end else if (wracc) begin
      if (k == 0) begin
        if (be[k][0]) mem_model[w[11:0]][7:0]  = wdata[k][7:0];
        if (be[k][1]) mem_model[w[11:0]][15:8] = wdata[k][15:8];
      end
      last_wr[k] = cyc + 1;
      wr_word[k] = w;
      wr_data[k] = wdata[k];
      wr_be[k]   = be[k];
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Holds one request until accepted; returns 1 time unit after the accept edge with the request dropped.
  task automatic applyStimulus(input int k, input logic r, input logic w, input logic [31:0] a,
                               input logic [15:0] d, input logic [1:0] b);
    logic stall;
    int   n;
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    n = 0;
    do begin
      @(negedge clk);
      stall = wreq[k];
      @(posedge clk);
      #1;
      n++;
    end while (stall && n < 40);
    if (stall) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL issue_timeout inst%0d: request at %0h still stalled after %0d cycles", k, a, n);
    end
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] q[$], input int idx, input logic [15:0] exp);
    n_checks++;
    if (idx >= q.size() || q[idx] !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h (of %0d results) expected %0h", name,
               (idx < q.size()) ? q[idx] : 16'hxxxx, q.size(), exp);
    end
  endtask

  initial begin
    rd = 2'b00; wr = 2'b00; lock = 2'b00;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; wdata[k] = '0; be[k] = '0;
      last_rd[k] = -100; last_wr[k] = -100;
    end
    max_pend[0] = 4;
    max_pend[1] = 2;
    for (int i = 0; i < 4096; i++) begin
      mem_model[i] = 16'(i);
      mem_pin[i]   = 16'(i);
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Eight back-to-back reads: one accept per clock, data equals the word index.
    t0 = cyc;
    for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 1'b0, 32'(i * 2), 16'h0, 2'b00);
    chk("burst_accept_cycles", 0, cyc - t0, 8);
    idle(6);
    chk("burst_count", 0, got0.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput("burst_data", got0, i, 16'(i));

    // MAX_PENDING=2: six reads take eight edges (2 accepts per 3 cycles).
    t0 = cyc;
    for (int i = 0; i < 6; i++) applyStimulus(1, 1'b1, 1'b0, 32'(16'h40 + i * 2), 16'h0, 2'b00);
    chk("throttle_accept_cycles", 1, cyc - t0, 8);
    idle(6);
    chk("throttle_count", 1, got1.size(), 6);
    for (int i = 0; i < 6; i++) checkOutput("throttle_data", got1, i, 16'(16'h20 + i));

    // Low-byte write then readback keeps the old upper byte.
    got0.delete();
    applyStimulus(0, 1'b0, 1'b1, 32'h100, 16'hA5C3, 2'b01);
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 16'h0, 2'b00);
    idle(5);
    checkOutput("lowbyte_readback", got0, 0, 16'h00C3);
    chk("model_mem_080", 0, mem_model[12'h080], 16'h00C3);

    // A byteenable=0 write must leave memory untouched.
    got0.delete();
    applyStimulus(0, 1'b0, 1'b1, 32'h120, 16'hFFFF, 2'b00);
    applyStimulus(0, 1'b1, 1'b0, 32'h120, 16'h0, 2'b00);
    idle(5);
    checkOutput("be0_readback", got0, 0, 16'h0090);

    // A write behind two pending reads is held until they return.
    got0.delete();
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 16'h0, 2'b00);
    applyStimulus(0, 1'b1, 1'b0, 32'h12, 16'h0, 2'b00);
    applyStimulus(0, 1'b0, 1'b1, 32'h140, 16'h1234, 2'b11);
    applyStimulus(0, 1'b1, 1'b0, 32'h140, 16'h0, 2'b00);
    idle(5);
    checkOutput("pending_rd0", got0, 0, 16'h0008);
    checkOutput("pending_rd1", got0, 1, 16'h0009);
    checkOutput("pending_wr_readback", got0, 2, 16'h1234);

    // Read and write together: the read is served, and the write waits. The address wraps to word 1.
    got0.delete();
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0020_0002; wdata[0] = 16'hBEEF; be[0] = 2'b11;
    idle(1);
    rd[0] = 1'b0;
    applyStimulus(0, 1'b0, 1'b1, 32'h0020_0002, 16'hBEEF, 2'b11);
    applyStimulus(0, 1'b1, 1'b0, 32'h0020_0002, 16'h0, 2'b00);
    idle(5);
    checkOutput("wrap_read_old", got0, 0, 16'h0001);
    checkOutput("wrap_read_new", got0, 1, 16'hBEEF);

    // A reset mid-burst drops the in-flight reads and leaves the responder free for a write.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 1'b0, 32'(i * 2), 16'h0, 2'b00);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    got0.delete();
    idle(8);
    chk("post_reset_returns", 0, got0.size(), 0);
    t0 = cyc;
    applyStimulus(0, 1'b0, 1'b1, 32'h160, 16'h5555, 2'b11);
    chk("post_reset_write_accept", 0, cyc - t0, 1);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
